// File: rtl/segdisp_capture_pkg.sv
// Shared types and constants for the 7-segment bus capture block.
// Used by segdisp_capture, its bus interface and seg7_decode.
package segcap_pkg;

    localparam int unsigned SEL_W      = 4;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned PAT_W      = 7;
    localparam int unsigned DIG_W      = 4;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned NUM_DIGITS = 4;

    // Segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [PAT_W-1:0] SEG_PAT_0     = 7'h3F;
    localparam logic [PAT_W-1:0] SEG_PAT_1     = 7'h06;
    localparam logic [PAT_W-1:0] SEG_PAT_2     = 7'h5B;
    localparam logic [PAT_W-1:0] SEG_PAT_3     = 7'h4F;
    localparam logic [PAT_W-1:0] SEG_PAT_4     = 7'h66;
    localparam logic [PAT_W-1:0] SEG_PAT_5     = 7'h6D;
    localparam logic [PAT_W-1:0] SEG_PAT_6     = 7'h7D;
    localparam logic [PAT_W-1:0] SEG_PAT_6_NOA = 7'h7C;
    localparam logic [PAT_W-1:0] SEG_PAT_7     = 7'h07;
    localparam logic [PAT_W-1:0] SEG_PAT_7_F   = 7'h27;
    localparam logic [PAT_W-1:0] SEG_PAT_8     = 7'h7F;
    localparam logic [PAT_W-1:0] SEG_PAT_9     = 7'h6F;
    localparam logic [PAT_W-1:0] SEG_PAT_9_NOD = 7'h67;
    localparam logic [PAT_W-1:0] SEG_PAT_BLANK = 7'h00;

    localparam logic [DIG_W-1:0] DIGIT_BLANK = 4'hF;
    localparam logic [DIG_W-1:0] DIGIT_ERR   = 4'hE;

    localparam int unsigned DIG_MIN     = 0;
    localparam int unsigned DIG_MINTEN  = 1;
    localparam int unsigned DIG_HOUR    = 2;
    localparam int unsigned DIG_HOURTEN = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } cap_state_e;

    // Packed so that slot index DIG_MIN lands in the low nibble
    typedef struct packed {
        logic [DIG_W-1:0] hourten;
        logic [DIG_W-1:0] hour;
        logic [DIG_W-1:0] minten;
        logic [DIG_W-1:0] min;
    } time_frame_t;

endpackage

// File: rtl/segdisp_capture_if.sv
// Multiplexed 7-segment display bus: anode select plus segment lines.
// master = display driver, slave = capture/reader.
interface segdisp_capture_if;
    import segcap_pkg::*;

    logic [SEL_W-1:0] digit_sel;
    logic [SEG_W-1:0] seg;

    modport master (output digit_sel, output seg);
    modport slave  (input  digit_sel, input  seg);
endinterface

// File: rtl/segdisp_capture_decode.sv
// Combinational 7-segment pattern to BCD decoder; blank -> 4'hF, unknown -> 4'hE.
module seg7_decode
    import segcap_pkg::*;
(
    input  logic [PAT_W-1:0] i_pat,
    output logic [DIG_W-1:0] o_value_c,
    output logic             o_err_c
);

    always_comb begin
        o_value_c = DIGIT_ERR;
        o_err_c   = 1'b0;
        case (i_pat)
            SEG_PAT_0:                    o_value_c = 4'd0;
            SEG_PAT_1:                    o_value_c = 4'd1;
            SEG_PAT_2:                    o_value_c = 4'd2;
            SEG_PAT_3:                    o_value_c = 4'd3;
            SEG_PAT_4:                    o_value_c = 4'd4;
            SEG_PAT_5:                    o_value_c = 4'd5;
            SEG_PAT_6, SEG_PAT_6_NOA:     o_value_c = 4'd6;
            SEG_PAT_7, SEG_PAT_7_F:       o_value_c = 4'd7;
            SEG_PAT_8:                    o_value_c = 4'd8;
            SEG_PAT_9, SEG_PAT_9_NOD:     o_value_c = 4'd9;
            SEG_PAT_BLANK:                o_value_c = DIGIT_BLANK;
            default: begin
                o_value_c = DIGIT_ERR;
                o_err_c   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/segdisp_capture.sv
// Reader for a multiplexed 4-digit 7-segment bus: settles, decodes and frames digits.
// Optional macro SEGCAP_PLAUSIBILITY_EN adds the registered bad_time output.
module segdisp_capture
    import segcap_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES    = 16,
    parameter bit          ANODE_ACTIVE_LOW = 1'b0,
    parameter bit          SEG_ACTIVE_LOW   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    segdisp_capture_if.slave bus,
    output logic [DIG_W-1:0] min,
    output logic [DIG_W-1:0] minten,
    output logic [DIG_W-1:0] hour,
    output logic [DIG_W-1:0] hourten,
    output logic             frame_valid,
    output logic             time_valid,
    output logic             changed,
    output logic             seg_err
`ifdef SEGCAP_PLAUSIBILITY_EN
    ,
    output logic             bad_time
`endif
);

    logic [SEL_W-1:0]                  r_sel_s1, r_sel_s2;
    logic [SEG_W-1:0]                  r_seg_s1, r_seg_s2;
    logic [SEL_W-1:0]                  w_sel;
    logic [SEG_W-1:0]                  w_seg;
    logic                              w_sel_valid;
    logic                              w_same;
    logic [SEL_W+SEG_W-1:0]            r_prev;

    cap_state_e                        r_state, w_state_nxt;
    logic [CNT_W-1:0]                  r_cnt, w_cnt_nxt;
    logic                              w_capture;

    logic [PAT_W-1:0]                  w_pat;
    logic [DIG_W-1:0]                  w_dec_value;
    logic                              w_dec_err;

    logic [NUM_DIGITS-1:0][DIG_W-1:0]  r_shadow, w_shadow_nxt;
    logic [SEL_W-1:0]                  r_mask, w_mask_nxt;
    logic                              w_frame_done, w_frame_err;
    time_frame_t                       r_frame, w_frame_new;
    logic                              r_any_frame;
    logic                              r_frame_valid, r_time_valid, r_changed, r_seg_err;

    // Two-flop synchronisers on the raw bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_s1 <= '0;
            r_sel_s2 <= '0;
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
        end else begin
            r_sel_s1 <= bus.digit_sel;
            r_sel_s2 <= r_sel_s1;
            r_seg_s1 <= bus.seg;
            r_seg_s2 <= r_seg_s1;
        end
    end

    assign w_sel       = ANODE_ACTIVE_LOW ? ~r_sel_s2 : r_sel_s2;
    assign w_seg       = SEG_ACTIVE_LOW   ? ~r_seg_s2 : r_seg_s2;
    assign w_sel_valid = $onehot(w_sel);
    assign w_same      = ({w_sel, w_seg} == r_prev);
    assign w_pat       = {w_seg[1], w_seg[2], w_seg[3], w_seg[4], w_seg[5], w_seg[6], w_seg[7]};

    seg7_decode u_decode (
        .i_pat     (w_pat),
        .o_value_c (w_dec_value),
        .o_err_c   (w_dec_err)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_prev  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_prev  <= {w_sel, w_seg};
        end
    end

    // Next-state: a digit is captured once per dwell after a stable run
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!w_sel_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_same) begin
                    w_cnt_nxt   = CNT_W'(1);
                end else if (r_cnt >= CNT_W'(SETTLE_CYCLES)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HELD;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!w_sel_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_same) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow slots, seen-mask and frame completion
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_mask_nxt   = r_mask;
        w_frame_err  = 1'b0;
        if (w_capture) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (w_sel[i]) w_shadow_nxt[i] = w_dec_value;
            end
            w_mask_nxt = r_mask | w_sel;
        end
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (w_shadow_nxt[i] == DIGIT_ERR) w_frame_err = 1'b1;
        end
        w_frame_done = (w_mask_nxt == {SEL_W{1'b1}});
        w_frame_new  = time_frame_t'(w_shadow_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow      <= '0;
            r_mask        <= '0;
            r_frame       <= '0;
            r_any_frame   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_time_valid  <= 1'b0;
            r_changed     <= 1'b0;
            r_seg_err     <= 1'b0;
        end else begin
            r_shadow      <= w_shadow_nxt;
            r_frame_valid <= w_frame_done;
            r_changed     <= w_frame_done && r_any_frame && (w_frame_new != r_frame);
            if (w_frame_done) begin
                r_mask      <= '0;
                r_frame     <= w_frame_new;
                r_any_frame <= 1'b1;
                r_seg_err   <= w_frame_err;
                if (!w_frame_err) r_time_valid <= 1'b1;
            end else begin
                r_mask <= w_mask_nxt;
                if (w_capture && w_dec_err) r_seg_err <= 1'b1;
            end
        end
    end

    assign min         = r_frame.min;
    assign minten      = r_frame.minten;
    assign hour        = r_frame.hour;
    assign hourten     = r_frame.hourten;
    assign frame_valid = r_frame_valid;
    assign time_valid  = r_time_valid;
    assign changed     = r_changed;
    assign seg_err     = r_seg_err;

`ifdef SEGCAP_PLAUSIBILITY_EN
    logic r_bad_time;

    // Blank is tolerated only as a suppressed leading hour-tens digit
    function automatic logic implausible(input time_frame_t f);
        logic b;
        b = 1'b0;
        if (f.hourten != DIGIT_BLANK && f.hourten > 4'd2)   b = 1'b1;
        if (f.hourten == 4'd2 && f.hour > 4'd3)             b = 1'b1;
        if (f.minten > 4'd5)                                b = 1'b1;
        if (f.hourten == DIGIT_ERR || f.hour == DIGIT_ERR ||
            f.minten == DIGIT_ERR || f.min == DIGIT_ERR)    b = 1'b1;
        if (f.hour == DIGIT_BLANK || f.minten == DIGIT_BLANK ||
            f.min == DIGIT_BLANK)                           b = 1'b1;
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad_time <= 1'b0;
        end else if (w_frame_done) begin
            r_bad_time <= implausible(w_frame_new);
        end
    end

    assign bad_time = r_bad_time;
`endif

endmodule

// File: tb/tb_segdisp_capture.sv
// Self-checking bench for segdisp_capture: randomized scans against a frame-level model.
// Define SEGCAP_PLAUSIBILITY_EN to also exercise bad_time.
module tb_segdisp_capture;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    segdisp_capture_if u_bus ();

    logic [3:0] min, minten, hour, hourten;
    logic       frame_valid, time_valid, changed, seg_err;
`ifdef SEGCAP_PLAUSIBILITY_EN
    logic       bad_time;
`endif

    segdisp_capture #(.SETTLE_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_bus),
        .min         (min),
        .minten      (minten),
        .hour        (hour),
        .hourten     (hourten),
        .frame_valid (frame_valid),
        .time_valid  (time_valid),
        .changed     (changed),
        .seg_err     (seg_err)
`ifdef SEGCAP_PLAUSIBILITY_EN
        ,
        .bad_time    (bad_time)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Frame pulse monitor
    int   fv_cnt     = 0;
    int   orphan_chg = 0;
    logic last_chg   = 1'b0;
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            last_chg = changed;
        end else if (changed) begin
            orphan_chg++;
        end
    end

    // Frame-level reference model
    bit          m_any;
    bit          m_tv;
    logic [15:0] m_prev;
    bit          e_chg;
    bit          e_err;

    function automatic bit has_err(input logic [15:0] f);
        return (f[15:12] == 4'hE) || (f[11:8] == 4'hE) || (f[7:4] == 4'hE) || (f[3:0] == 4'hE);
    endfunction

    task automatic model_reset();
        m_any  = 1'b0;
        m_tv   = 1'b0;
        m_prev = 16'h0000;
    endtask

    task automatic model_frame(input logic [15:0] f);
        e_chg  = m_any && (f != m_prev);
        e_err  = has_err(f);
        if (!e_err) m_tv = 1'b1;
        m_any  = 1'b1;
        m_prev = f;
    endtask

`ifdef SEGCAP_PLAUSIBILITY_EN
    function automatic bit model_bad(input logic [15:0] f);
        int ht, h, mt, m;
        ht = int'(f[15:12]); h = int'(f[11:8]); mt = int'(f[7:4]); m = int'(f[3:0]);
        if (has_err(f)) return 1'b1;
        if (h == 15 || mt == 15 || m == 15) return 1'b1;
        if (ht != 15 && ht > 2) return 1'b1;
        if (ht == 2 && h > 3) return 1'b1;
        if (mt > 5) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Standard segment patterns {g,f,e,d,c,b,a}; digit 4'hE stands for a garbage pattern
    function automatic logic [6:0] pat_of(input logic [3:0] d, input bit alt);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return alt ? 7'h7C : 7'h7D;
            4'd7: return alt ? 7'h27 : 7'h07;
            4'd8: return 7'h7F;
            4'd9: return alt ? 7'h67 : 7'h6F;
            4'hF: return 7'h00;
            default: return 7'b1010101;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d, input bit alt, input bit dp);
        logic [6:0] p;
        p = pat_of(d, alt);
        return {p[0], p[1], p[2], p[3], p[4], p[5], p[6], dp};
    endfunction

    task automatic set_bus(input logic [3:0] sel, input logic [7:0] s);
        u_bus.digit_sel = sel;
        u_bus.seg       = s;
    endtask

    task automatic drive_digit(input int idx, input logic [7:0] s, input int hold);
        @(negedge clk);
        set_bus(4'(1 << idx), s);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] f, input bit ghost);
        int          order[4];
        int          t, j, idx, gap;
        logic [7:0]  s, prev_seg;
        order = '{0, 1, 2, 3};
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        prev_seg = 8'h00;
        for (int k = 0; k < 4; k++) begin
            idx = order[k];
            s   = seg_of(f[idx*4 +: 4], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (ghost) begin
                @(negedge clk);
                set_bus(4'(1 << idx), prev_seg);
                repeat (4) @(negedge clk);
            end
            drive_digit(idx, s, 40 + $urandom_range(0, 30));
            prev_seg = s;
            gap = ghost ? 0 : $urandom_range(0, 3);
            if (gap > 0) begin
                @(negedge clk);
                set_bus(4'b0000, 8'h00);
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        set_bus(4'b0000, 8'h00);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_bus(4'b0000, 8'h00);
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({hourten, hour, minten, min, frame_valid, time_valid, changed, seg_err} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {hourten, hour, minten, min, frame_valid, time_valid, changed, seg_err});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int base;
        base = fv_cnt;
        scan(16'h1234, 1'b0);
        model_frame(16'h1234);
        checks++;
        if (fv_cnt - base !== 1) begin
            failures++; $display("FAIL basic_frame_count got=%0d want=1", fv_cnt - base);
        end
        checks++;
        if ({hourten, hour, minten, min} !== 16'h1234) begin
            failures++; $display("FAIL basic_digits got=%h want=1234", {hourten, hour, minten, min});
        end
        checks++;
        if (time_valid !== m_tv || last_chg !== e_chg) begin
            failures++; $display("FAIL basic_flags got tv=%b chg=%b want tv=%b chg=%b",
                                 time_valid, last_chg, m_tv, e_chg);
        end
    endtask

    task automatic test_changed();
        int base;
        base = fv_cnt;
        scan(16'h1235, 1'b0);
        model_frame(16'h1235);
        checks++;
        if (fv_cnt - base !== 1 || last_chg !== e_chg) begin
            failures++; $display("FAIL changed_pulse got fv=%0d chg=%b want fv=1 chg=%b",
                                 fv_cnt - base, last_chg, e_chg);
        end
        checks++;
        if ({hourten, hour, minten, min} !== 16'h1235) begin
            failures++; $display("FAIL changed_digits got=%h want=1235", {hourten, hour, minten, min});
        end
    endtask

    task automatic test_ghost();
        int base;
        base = fv_cnt;
        scan(16'h2147, 1'b1);
        model_frame(16'h2147);
        checks++;
        if (fv_cnt - base !== 1) begin
            failures++; $display("FAIL ghost_frame_count got=%0d want=1", fv_cnt - base);
        end
        checks++;
        if ({hourten, hour, minten, min} !== 16'h2147 || seg_err !== 1'b0) begin
            failures++; $display("FAIL ghost_digits got=%h err=%b want=2147 err=0",
                                 {hourten, hour, minten, min}, seg_err);
        end
    endtask

    task automatic test_seg_err();
        scan(16'h1E34, 1'b0);
        model_frame(16'h1E34);
        checks++;
        if (hour !== 4'hE || seg_err !== e_err || time_valid !== m_tv) begin
            failures++; $display("FAIL err_frame got hour=%h err=%b tv=%b want hour=e err=%b tv=%b",
                                 hour, seg_err, time_valid, e_err, m_tv);
        end
        scan(16'h1234, 1'b0);
        model_frame(16'h1234);
        checks++;
        if (seg_err !== e_err || {hourten, hour, minten, min} !== 16'h1234 || last_chg !== e_chg) begin
            failures++; $display("FAIL err_clear got err=%b val=%h chg=%b want err=%b val=1234 chg=%b",
                                 seg_err, {hourten, hour, minten, min}, last_chg, e_err, e_chg);
        end
    endtask

    task automatic test_double_sel();
        int base;
        base = fv_cnt;
        @(negedge clk);
        set_bus(4'b0011, seg_of(4'd8, 1'b0, 1'b0));
        repeat (200) @(negedge clk);
        set_bus(4'b0000, 8'h00);
        repeat (10) @(negedge clk);
        checks++;
        if (fv_cnt - base !== 0 || {hourten, hour, minten, min} !== m_prev) begin
            failures++; $display("FAIL double_sel got fv=%0d val=%h want fv=0 val=%h",
                                 fv_cnt - base, {hourten, hour, minten, min}, m_prev);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = fv_cnt;
        drive_digit(0, seg_of(4'd9, 1'b0, 1'b0), 50);
        drive_digit(1, seg_of(4'd5, 1'b0, 1'b0), 50);
        drive_digit(2, seg_of(4'd9, 1'b0, 1'b0), 50);
        @(negedge clk);
        set_bus(4'b0000, 8'h00);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({hourten, hour, minten, min, time_valid, seg_err} !== 18'h0) begin
            failures++; $display("FAIL midreset_outputs got=%h want=0",
                                 {hourten, hour, minten, min, time_valid, seg_err});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        scan(16'h0815, 1'b0);
        model_frame(16'h0815);
        checks++;
        if (fv_cnt - base !== 1 || {hourten, hour, minten, min} !== 16'h0815) begin
            failures++; $display("FAIL midreset_frame got fv=%0d val=%h want fv=1 val=0815",
                                 fv_cnt - base, {hourten, hour, minten, min});
        end
        checks++;
        if (last_chg !== e_chg || time_valid !== m_tv) begin
            failures++; $display("FAIL midreset_flags got chg=%b tv=%b want chg=%b tv=%b",
                                 last_chg, time_valid, e_chg, m_tv);
        end
    endtask

    task automatic test_random();
        int          base;
        logic [15:0] f;
        logic [3:0]  ht_tab [4];
        ht_tab = '{4'd0, 4'd1, 4'd2, 4'hF};
        for (int n = 0; n < 8; n++) begin
            f[15:12] = ht_tab[$urandom_range(0, 3)];
            f[11:8]  = 4'($urandom_range(0, 9));
            f[7:4]   = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 9 : 5));
            f[3:0]   = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) f[4*$urandom_range(0, 3) +: 4] = 4'hE;
            base = fv_cnt;
            scan(f, 1'($urandom_range(0, 1)));
            model_frame(f);
            checks++;
            if (fv_cnt - base !== 1 || {hourten, hour, minten, min} !== f) begin
                failures++; $display("FAIL random_frame n=%0d got fv=%0d val=%h want fv=1 val=%h",
                                     n, fv_cnt - base, {hourten, hour, minten, min}, f);
            end
            checks++;
            if (last_chg !== e_chg || seg_err !== e_err || time_valid !== m_tv) begin
                failures++; $display("FAIL random_flags n=%0d got chg=%b err=%b tv=%b want chg=%b err=%b tv=%b",
                                     n, last_chg, seg_err, time_valid, e_chg, e_err, m_tv);
            end
`ifdef SEGCAP_PLAUSIBILITY_EN
            checks++;
            if (bad_time !== model_bad(f)) begin
                failures++; $display("FAIL random_bad_time n=%0d got=%b want=%b", n, bad_time, model_bad(f));
            end
`endif
        end
    endtask

`ifdef SEGCAP_PLAUSIBILITY_EN
    task automatic test_plausibility();
        scan(16'h2961, 1'b0);
        model_frame(16'h2961);
        checks++;
        if (bad_time !== 1'b1) begin
            failures++; $display("FAIL plaus_2961 got=%b want=1", bad_time);
        end
        scan(16'hF959, 1'b0);
        model_frame(16'hF959);
        checks++;
        if (bad_time !== 1'b0) begin
            failures++; $display("FAIL plaus_blank_lead got=%b want=0", bad_time);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_changed();
        test_ghost();
        test_seg_err();
        test_double_sel();
        test_reset_mid();
        test_random();
`ifdef SEGCAP_PLAUSIBILITY_EN
        test_plausibility();
`endif
        checks++;
        if (orphan_chg !== 0) begin
            failures++; $display("FAIL changed_without_frame got=%0d want=0", orphan_chg);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segdisp_capture.md
Name: segdisp_capture

Overview:
- Reader end of the multiplexed 4-digit 7-segment bus driven by the display path.
- Samples anode-select and segment lines, waits for each digit to settle, and decodes segment patterns back to BCD.
- Assembles complete frames of {hourten, hour, minten, min}.
- Used for board-level self-check, for a second board mirroring the display, and as the bench monitor for display-path verification.

Parameters:
- SETTLE_CYCLES, 16: consecutive identical samples required before a digit is captured (anti-ghosting); legal range 1..255.
- ANODE_ACTIVE_LOW, 0: 1 means a digit is selected when its digit_sel bit is 0.
- SEG_ACTIVE_LOW, 0: 1 means a segment is lit when its seg bit is 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digit_sel  in  4  anode select; bit0=min, bit1=minten, bit2=hour, bit3=hourten
- seg  in  8  segments {a,b,c,d,e,f,g,dp}, seg[7]=a
- min  out  4  captured minute units
- minten  out  4  captured minute tens
- hour  out  4  captured hour units
- hourten  out  4  captured hour tens
- frame_valid  out  1  one-cycle pulse when a new complete frame is latched to the outputs
- time_valid  out  1  level; high once the first good frame is latched
- changed  out  1  one-cycle pulse, coincident with frame_valid, when any output digit differs from the previous frame
- seg_err  out  1  sticky; set on an undecodable settled pattern; cleared by reset or by the next error-free frame

Behaviour:
- Reset: every output is 0. Synchronisers, FSM, settle counter, seen-mask and shadow registers are cleared.
- Input conditioning:
  - digit_sel and seg pass through 2-flop synchronisers.
  - Polarity is normalised per the parameters. After normalisation, 1 means selected or lit.
- Selection:
  - Exactly one normalised digit_sel bit set means a valid select.
  - Zero bits or more than one bit set means no select.
- FSM states: IDLE, SETTLE, HELD.
  - IDLE → SETTLE on a valid select; the settle counter loads 1.
  - SETTLE: if {sel, seg} equals the previous sample, the counter increments. Any difference reloads the counter to 1. No select returns to IDLE.
  - SETTLE, when the counter reaches SETTLE_CYCLES: capture the decoded digit into the shadow slot for that select, set its seen-mask bit, go to HELD.
  - HELD → SETTLE on any change of {sel, seg}. HELD → IDLE on no select. A digit is captured at most once per select dwell.
- Decode, on g-f-e-d-c-b-a ignoring dp:
  - Digits 0–9 use standard patterns. 6 is accepted with or without a; 7 with or without f; 9 with or without d.
  - All segments off decodes as blank, value 4'hF.
  - Any other pattern decodes as 4'hE and marks the frame erroneous.
- Frame handling:
  - When the seen-mask becomes 4'b1111, all four shadow slots are copied to the outputs in the same cycle. frame_valid pulses and the mask clears.
  - changed pulses in that cycle if any output value differs from its prior value; it is not asserted on the first frame after reset.
  - time_valid is set on the first error-free frame. An erroneous frame is still latched, sets seg_err, and does not clear time_valid.
- Latency: output update occurs 2 (sync) + SETTLE_CYCLES + 1 cycles after the last-needed digit becomes stable.
- Recapture: if a digit is recaptured before the frame completes, the newer value overwrites its shadow slot.
- Reset mid-frame: partial frames are discarded and no frame_valid is produced.

Optional Feature:
- Macro: SEGCAP_PLAUSIBILITY_EN.
- Defined: adds output bad_time, 1 bit, registered and updated with each frame. bad_time=1 when any of the following holds:
  - hourten > 2
  - hourten == 2 and hour > 3
  - minten > 5
  - any digit is 4'hE
  - blank appears anywhere other than hourten
- Not defined: port absent; no checking logic.

Decomposition:
- Shared package segcap_pkg holds:
  - the 7-bit segment pattern constants for 0–9
  - DIGIT_BLANK = 4'hF and DIGIT_ERR = 4'hE
  - FSM state enum
  - digit index constants
- One sub-module, seg7_decode: purely combinational, 7-bit pattern in, 4-bit value plus err out. Instantiated once on the synchronised seg.

Test Plan:
- Scan "12:34" (hourten=1, hour=2, minten=3, min=4), each digit held 64 cycles, SETTLE_CYCLES=16 → one frame_valid; outputs 1,2,3,4; time_valid=1; changed=0.
- Repeat the scan with min=5 → frame_valid plus changed pulse; min=5; other outputs unchanged.
- Ghosting: hold the new digit_sel with the previous seg pattern for 5 cycles before the correct pattern → no capture of the ghost value; outputs exact.
- Pattern 7'b1010101 on the hour slot → hour=4'hE; seg_err=1. A following clean frame clears seg_err.
- Two digit_sel bits set for 200 cycles → FSM in IDLE; no capture; no frame_valid.
- rst_n asserted after 3 of 4 digits captured, then one full scan → exactly one frame_valid, from the post-reset scan only. With SEGCAP_PLAUSIBILITY_EN: "29:61" → bad_time=1.
